// File: rtl/f1_seq_param.sv
// Sequential lamp filler: lamps light one per tick, all-on hold, then clear with a done pulse.
// Optional F1_RANDOM_HOLD_EN replaces the fixed HOLD_TICKS hold with a free-running 7-bit LFSR value.
`timescale 1ns/1ps

module f1_seq_param #(
  parameter int LIGHTS     = 8,
  parameter int N_WIDTH    = 16,
  parameter int HOLD_TICKS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_WIDTH-1:0] N,
  input  logic               trigger,
  output logic [LIGHTS-1:0]  data_out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [N_WIDTH-1:0] presc;
  logic [6:0]         hold_cnt;
  logic [6:0]         hold_value;
  logic               tick;
  logic               fill_last;
  logic               hold_last;

`ifdef F1_RANDOM_HOLD_EN
  // x^7 + x^3 + 1 Fibonacci LFSR; free-running so the hold length varies run to run.
  logic [6:0] lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= 7'h01;
    end else begin
      lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[2]};
    end
  end

  assign hold_value = lfsr;
`else
  assign hold_value = 7'(HOLD_TICKS);
`endif

  assign tick      = (state != IDLE) && (presc == '0);
  assign fill_last = tick && (state == FILL) && (&data_out[LIGHTS-2:0]);
  assign hold_last = tick && (state == HOLD) && (hold_cnt == 7'd1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger)   state_nxt = FILL;
      FILL:    if (fill_last) state_nxt = HOLD;
      HOLD:    if (hold_last) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Prescaler, lamp register, hold counter and done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc    <= '0;
      hold_cnt <= '0;
      data_out <= '0;
      done     <= 1'b0;
    end else begin
      done <= hold_last;
      case (state)
        IDLE: begin
          data_out <= '0;
          hold_cnt <= '0;
          presc    <= trigger ? N : '0;
        end
        FILL: begin
          presc <= tick ? N : presc - N_WIDTH'(1);
          if (tick) begin
            data_out <= {data_out[LIGHTS-2:0], 1'b1};
          end
          if (fill_last) begin
            hold_cnt <= hold_value;
          end
        end
        HOLD: begin
          if (!tick) begin
            presc <= presc - N_WIDTH'(1);
          end else if (hold_last) begin
            presc    <= '0;
            hold_cnt <= '0;
            data_out <= '0;
          end else begin
            presc    <= N;
            hold_cnt <= hold_cnt - 7'd1;
          end
        end
        default: begin
          presc    <= '0;
          hold_cnt <= '0;
          data_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_f1_seq_param.sv
// Bench for f1_seq_param: tick-schedule reference model, directed scenarios plus randomized runs.
`timescale 1ns/1ps

module tb_f1_seq_param;

  localparam int L8  = 8;
  localparam int H8  = 3;
  localparam int L4  = 4;
  localparam int H4  = 1;
  localparam int NW  = 16;
  localparam int BIG = 32'h3fff_ffff;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NW-1:0] n8, n4;
  logic          trig8, trig4;
  logic [L8-1:0] out8;
  logic [L4-1:0] out4;
  logic          busy8, done8, busy4, done4;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  f1_seq_param #(.LIGHTS(L8), .N_WIDTH(NW), .HOLD_TICKS(H8)) u_dut8 (
    .clk(clk), .rst(rst), .N(n8), .trigger(trig8),
    .data_out(out8), .busy(busy8), .done(done8)
  );

  f1_seq_param #(.LIGHTS(L4), .N_WIDTH(NW), .HOLD_TICKS(H4)) u_dut4 (
    .clk(clk), .rst(rst), .N(n4), .trigger(trig4),
    .data_out(out4), .busy(busy4), .done(done4)
  );

`ifdef F1_RANDOM_HOLD_EN
  // Reference LFSR; m_lfsr_prev holds the value seen just before the latest edge.
  int m_lfsr, m_lfsr_prev;

  function automatic int lfsr_step(input int v);
    return ((v << 1) & 'h7f) | (((v >> 6) ^ (v >> 2)) & 1);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_lfsr      <= 1;
      m_lfsr_prev <= 1;
    end else begin
      m_lfsr_prev <= m_lfsr;
      m_lfsr      <= lfsr_step(m_lfsr);
    end
  end
`endif

  always @(negedge clk) begin
    if (done8) done_cnt <= done_cnt + 1;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One sequence on the 8-lamp instance. N switches to n_second for edges after switch_t.
  task automatic run8(input int n_first, input int n_second, input int switch_t,
                      input bit keep_trig, output int obs_done_t, output int hold);
    int          ticks, next_tick, cur_n;
    logic [31:0] exp_out;
    bit          exp_done;
    trig8 = 1'b1;
    n8    = NW'(n_first);
    step();
    if (!keep_trig) trig8 = 1'b0;
    check("start_busy8", busy8, 1);
    check("start_out8", out8, 0);
    ticks      = 0;
    next_tick  = n_first + 1;
    hold       = 0;
    obs_done_t = -1;
    for (int t = 1; t <= 4000; t++) begin
      cur_n = (t > switch_t) ? n_second : n_first;
      n8    = NW'(cur_n);
      step();
      exp_done = 1'b0;
      if (t == next_tick) begin
        ticks++;
        next_tick = t + cur_n + 1;
        if (ticks == L8) begin
`ifdef F1_RANDOM_HOLD_EN
          hold = m_lfsr_prev;
`else
          hold = H8;
`endif
        end
        if (ticks > L8 && ticks == L8 + hold) exp_done = 1'b1;
      end
      if (exp_done)        exp_out = 0;
      else if (ticks < L8) exp_out = (32'd1 << ticks) - 1;
      else                 exp_out = (32'd1 << L8) - 1;
      if (done8 && obs_done_t < 0) obs_done_t = t;
      check("out8", {24'd0, out8}, exp_out);
      check("done8", done8, exp_done);
      check("busy8", busy8, !exp_done);
      if (exp_done) break;
    end
  endtask

  initial begin
    int dt, h, snap, ticks, hold;
    bit exp_done;
    logic [31:0] exp_out;

    trig8 = 1'b0;
    trig4 = 1'b0;
    n8    = '0;
    n4    = '0;
    repeat (2) step();
    check("rst_out8", {24'd0, out8}, 0);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_out4", {28'd0, out4}, 0);
    check("rst_busy4", busy4, 0);
    rst = 1'b1;
    repeat (3) begin
      step();
      check("idle_out8", {24'd0, out8}, 0);
      check("idle_busy8", busy8, 0);
    end

    // Basic run N=4: 0x01 at +5, 0xFF at +40, done at (8+hold)*5.
    run8(4, 4, BIG, 1'b0, dt, h);
    check("len_n4", dt, (L8 + h) * 5);

    // N=0 on the 4-lamp instance: one lamp per cycle.
    trig4 = 1'b1;
    n4    = '0;
    step();
    trig4 = 1'b0;
    check("start_busy4", busy4, 1);
    hold = 0;
    for (int t = 1; t <= 200; t++) begin
      step();
      ticks = t;
      if (t == L4) begin
`ifdef F1_RANDOM_HOLD_EN
        hold = m_lfsr_prev;
`else
        hold = H4;
`endif
      end
      exp_done = (t > L4) && (t == L4 + hold);
      if (exp_done)        exp_out = 0;
      else if (ticks < L4) exp_out = (32'd1 << ticks) - 1;
      else                 exp_out = (32'd1 << L4) - 1;
      check("out4", {28'd0, out4}, exp_out);
      check("done4", done4, exp_done);
      if (exp_done) break;
    end

    // Trigger held high: back-to-back sequences, one done each.
    snap = done_cnt;
    run8(2, 2, BIG, 1'b1, dt, h);
    check("b2b_len1", dt, (L8 + h) * 3);
    run8(2, 2, BIG, 1'b1, dt, h);
    trig8 = 1'b0;
    check("b2b_len2", dt, (L8 + h) * 3);
    step();
    check("b2b_done_count", done_cnt - snap, 2);
    check("b2b_idle", busy8, 0);

    // N changes 4 -> 9 during FILL: first period 5 cycles, then 10.
    run8(4, 9, 2, 1'b0, dt, h);

    // Asynchronous reset at 0x07 abandons the sequence without done.
    trig8 = 1'b1;
    n8    = NW'(4);
    step();
    trig8 = 1'b0;
    repeat (15) step();
    check("pre_rst_out8", {24'd0, out8}, 32'h07);
    #2;
    rst = 1'b0;
    #1;
    check("async_out8", {24'd0, out8}, 0);
    check("async_busy8", busy8, 0);
    check("async_done8", done8, 0);
    snap = done_cnt;
    repeat (3) step();
    check("rst_no_done", done_cnt - snap, 0);
    rst = 1'b1;
    run8(4, 4, BIG, 1'b0, dt, h);
    check("post_rst_len", dt, (L8 + h) * 5);

    // Repeated N=1 runs (hold source exercised across several LFSR values).
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) step();
      run8(1, 1, BIG, 1'b0, dt, h);
      check("n1_len", dt, (L8 + h) * 2);
    end

    // Randomized runs: N, mid-run N change, idle gaps, trigger held or pulsed.
    for (int i = 0; i < 6; i++) begin
      int nf, ns, sw, gap;
      bit kt;
      nf  = $urandom_range(0, 5);
      ns  = $urandom_range(0, 5);
      sw  = $urandom_range(1, 30);
      gap = $urandom_range(0, 3);
      kt  = 1'($urandom_range(0, 1));
      run8(nf, ns, sw, kt, dt, h);
      trig8 = 1'b0;
      check("rand_done_seen", (dt > 0), 1);
      repeat (gap) begin
        step();
        check("rand_gap_busy8", busy8, 0);
        check("rand_gap_out8", {24'd0, out8}, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
